// File: rtl/sb_tx_pkt_scheduler.sv
// -----------------------------------------------------------------------------
// sb_tx_pkt_scheduler
//
// Sideband TX packet scheduler. Two message sources (requester 0: link
// management, requester 1: RDI/FDI messages) share one serial sideband lane.
// A round-robin arbiter picks a source, the granted DATA_W-bit packet is
// shifted out LSB-first at one bit per UI, and the forwarded clock enable is
// high only while data bits are on the lane. Every packet is followed by
// GAP_UI clock-gated idle UIs before the next one can start.
//
// Ports:
//   i_pll_clk     PLL clock, one UI per cycle
//   i_rst         synchronous active-high reset
//   i_sb_en       scheduler enable; low blocks new grants only
//   i_req0_valid  requester 0 has a packet
//   i_req0_data   requester 0 packet, held stable while valid
//   o_req0_ready  requester 0 packet accepted this cycle when valid
//   i_req1_valid  requester 1 has a packet
//   i_req1_data   requester 1 packet
//   o_req1_ready  requester 1 accept
//   o_txdat       serial sideband data (registered)
//   o_clk_en      forwarded sideband clock gate enable (registered)
//   o_pkt_done    one-cycle pulse on the last data UI (registered)
//   o_busy        high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module sb_tx_pkt_scheduler #(
  parameter int DATA_W = 64,
  parameter int GAP_UI = 32
) (
  input  logic              i_pll_clk,
  input  logic              i_rst,
  input  logic              i_sb_en,
  input  logic              i_req0_valid,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_txdat,
  output logic              o_clk_en,
  output logic              o_pkt_done,
  output logic              o_busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_UI > 1) ? $clog2(GAP_UI) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_PENULT = BIT_W'(DATA_W - 2);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_UI - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              rr_ptr;

  logic              accept_win;
  logic              grant_open;
  logic              pick1;
  logic              accept;
  logic [DATA_W-1:0] sel_data;

  // The lane can take a new packet when idle, or on the final gap UI so that
  // back-to-back packets are separated by exactly GAP_UI gated UIs.
  assign accept_win = (state == ST_IDLE) ||
                      ((state == ST_GAP) && (gap_cnt == GAP_LAST));
  assign grant_open = accept_win && i_sb_en;

  // A lone requester always wins; the pointer only breaks ties.
  assign pick1 = i_req1_valid && (!i_req0_valid || rr_ptr);

  assign o_req0_ready = grant_open && i_req0_valid && !pick1;
  assign o_req1_ready = grant_open && i_req1_valid &&  pick1;
  assign accept       = o_req0_ready || o_req1_ready;
  assign sel_data     = pick1 ? i_req1_data : i_req0_data;

  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_pll_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shift_reg  <= '0;
      rr_ptr     <= 1'b0;
      o_txdat    <= 1'b0;
      o_clk_en   <= 1'b0;
      o_pkt_done <= 1'b0;
    end else begin
      o_pkt_done <= 1'b0;
      if (accept) begin
        // Bit 0 goes straight to the output register so the first data UI
        // is the cycle right after acceptance; the rest waits in shift_reg.
        state     <= ST_SEND;
        bit_cnt   <= '0;
        gap_cnt   <= '0;
        shift_reg <= sel_data >> 1;
        o_txdat   <= sel_data[0];
        o_clk_en  <= 1'b1;
        rr_ptr    <= ~pick1;
      end else begin
        case (state)
          ST_SEND: begin
            if (bit_cnt == BIT_LAST) begin
              state    <= ST_GAP;
              bit_cnt  <= '0;
              gap_cnt  <= '0;
              o_txdat  <= 1'b0;
              o_clk_en <= 1'b0;
            end else begin
              bit_cnt    <= bit_cnt + BIT_W'(1);
              o_txdat    <= shift_reg[0];
              shift_reg  <= shift_reg >> 1;
              // Pulse lines up with the UI that carries the final bit.
              o_pkt_done <= (bit_cnt == BIT_PENULT);
            end
          end
          ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state   <= ST_IDLE;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          ST_IDLE: begin
            o_txdat  <= 1'b0;
            o_clk_en <= 1'b0;
          end
          default: begin
            state    <= ST_IDLE;
            o_txdat  <= 1'b0;
            o_clk_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
